// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for the async FIFO: header {tag, seq}, payload beats, trailer with beat count.
// Optional statistics outputs (pkt_cnt, stall_cnt) are enabled by defining FIFO_PKT_WR_STATS_EN.
module fifo_pkt_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_WIDTH  = 4,
    parameter logic [DATA_WIDTH-SEQ_WIDTH-1:0] HDR_TAG = 4'hA
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  busy
`ifdef FIFO_PKT_WR_STATS_EN
    ,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TRL  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] LEN_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] LEN_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEQ_WIDTH-1:0]  SEQ_ONE = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;

    // Next-state and write-port decode; rst gates the write strobe while held.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        len_d      = len_q;
        s_ready    = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_data  = {HDR_TAG, seq_q};
        case (state_q)
            IDLE: begin
                fifo_wr_en = s_valid && !fifo_full && !rst;
                if (fifo_wr_en) begin
                    len_d   = {DATA_WIDTH{1'b0}};
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                s_ready    = !fifo_full && !rst;
                fifo_data  = s_data;
                fifo_wr_en = s_valid && s_ready;
                if (fifo_wr_en) begin
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + LEN_ONE;
                    end else begin
                        len_d = len_q;
                    end
                    if (s_last) begin
                        state_d = TRL;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            TRL: begin
                fifo_data  = len_q;
                fifo_wr_en = !fifo_full && !rst;
                if (fifo_wr_en) begin
                    seq_d   = seq_q + SEQ_ONE;
                    state_d = IDLE;
                end else begin
                    state_d = TRL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Framer state registers.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seq_q   <= {SEQ_WIDTH{1'b0}};
            len_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef FIFO_PKT_WR_STATS_EN
    logic        pending_s;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A write is pending in TRL unconditionally, elsewhere only with s_valid.
    always_comb begin
        pending_s   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            IDLE:    pending_s = s_valid;
            DATA:    pending_s = s_valid;
            TRL:     pending_s = 1'b1;
            default: pending_s = 1'b0;
        endcase
        if ((state_q == TRL) && fifo_wr_en) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (pending_s && fifo_full) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Statistics counters, wrapping at 16 bits.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer: expected FIFO words are queued as stimulus is driven
// and popped by a write monitor; scenario tasks add inline timing/handshake checks.
module tb_fifo_pkt_writer;

    logic       wr_clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_data;
    logic       busy;
`ifdef FIFO_PKT_WR_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    logic [7:0] sb[$];
    logic [3:0] exp_seq = 4'd0;

    fifo_pkt_writer #(.DATA_WIDTH(8), .SEQ_WIDTH(4), .HDR_TAG(4'hA)) dut (
        .wr_clk(wr_clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy)
`ifdef FIFO_PKT_WR_STATS_EN
        , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Write monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge wr_clk) begin
        logic [7:0] exp_d;
        if (fifo_wr_en === 1'b1) begin
            wr_count++;
            last_wr_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h, expected no write (cycle %0d)", fifo_data, cyc);
            end else begin
                exp_d = sb.pop_front();
                if (fifo_data !== exp_d) begin
                    errors++;
                    $display("FAIL fifo_data: got %h, expected %h (cycle %0d)", fifo_data, exp_d, cyc);
                end
            end
        end
        if (fifo_full === 1'b1 || rst === 1'b1) begin
            checks++;
            if (fifo_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL wr_en_blocked: got %b, expected 0 (full=%b rst=%b)", fifo_wr_en, fifo_full, rst);
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; fifo_full = 1'b0;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b ready=%b wr_en=%b, expected 0/0/0", busy, s_ready, fifo_wr_en);
        end
        @(posedge wr_clk); #1;
        rst = 1'b0;
        exp_seq = 4'd0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge wr_clk);
        while ((busy !== 1'b0 || fifo_wr_en !== 1'b0) && t < 50) begin
            t++;
            @(negedge wr_clk);
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: got busy=%b, expected 0 within 50 cycles", busy);
        end
        @(posedge wr_clk); #1;
    endtask

    task automatic send_pkt(input int n, input logic [7:0] base, input bit keep_valid);
        int t;
        sb.push_back({4'hA, exp_seq});
        for (int i = 0; i < n; i++) sb.push_back(base + 8'(i));
        sb.push_back((n > 255) ? 8'hFF : 8'(n));
        exp_seq = exp_seq + 4'd1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = base + 8'(i); s_last = (i == n - 1);
            t = 0;
            @(negedge wr_clk);
            while (s_ready !== 1'b1 && t < 100) begin
                t++;
                @(negedge wr_clk);
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got s_ready=%b, expected 1 within 100 cycles", s_ready);
            end
            @(posedge wr_clk); #1;
        end
        if (!keep_valid) begin
            s_valid = 1'b0; s_last = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
`ifdef FIFO_PKT_WR_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: got pkt=%0d stall=%0d, expected 0/0", pkt_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        int c0, w0;
        sb.push_back(8'hA0); sb.push_back(8'h11); sb.push_back(8'h22);
        sb.push_back(8'h33); sb.push_back(8'h03);
        exp_seq = exp_seq + 4'd1;
        c0 = cyc; w0 = wr_count;
        s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
        @(negedge wr_clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_hdr: got %b, expected 0", busy); end
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            errors++; $display("FAIL basic_data_cycle: got busy=%b ready=%b, expected 1/1", busy, s_ready);
        end
        @(posedge wr_clk); #1; s_data = 8'h22;
        @(posedge wr_clk); #1; s_data = 8'h33; s_last = 1'b1;
        @(posedge wr_clk); #1; s_valid = 1'b0; s_last = 1'b0;
        @(negedge wr_clk);
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL basic_trl_cycle: got busy=%b ready=%b, expected 1/0", busy, s_ready);
        end
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: got busy=%b wr_en=%b, expected 0/0", busy, fifo_wr_en);
        end
        checks++;
        if (wr_count - w0 !== 5 || last_wr_cyc - c0 !== 4) begin
            errors++; $display("FAIL basic_timing: got writes=%0d span=%0d, expected 5/4", wr_count - w0, last_wr_cyc - c0);
        end
        @(posedge wr_clk); #1;
    endtask

    task automatic test_back_to_back();
        int c0, w0;
        c0 = cyc; w0 = wr_count;
        send_pkt(2, 8'h40, 1'b1);
        send_pkt(2, 8'h50, 1'b0);
        wait_idle();
        checks++;
        if (wr_count - w0 !== 8 || last_wr_cyc - c0 !== 7) begin
            errors++; $display("FAIL b2b_timing: got writes=%0d span=%0d, expected 8/7", wr_count - w0, last_wr_cyc - c0);
        end
    endtask

    task automatic test_single();
        send_pkt(1, 8'h55, 1'b0);
        wait_idle();
    endtask

    task automatic test_full_stall();
        apply_reset();
        sb.push_back(8'hA0); sb.push_back(8'h61); sb.push_back(8'h62); sb.push_back(8'h02);
        exp_seq = exp_seq + 4'd1;
        s_valid = 1'b1; s_data = 8'h61; s_last = 1'b0;
        @(posedge wr_clk); #1;
        @(posedge wr_clk); #1;
        s_data = 8'h62; s_last = 1'b1; fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            checks++;
            if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL full_stall_%0d: got ready=%b wr_en=%b busy=%b, expected 0/0/1", i, s_ready, fifo_wr_en, busy);
            end
            @(posedge wr_clk); #1;
        end
        fifo_full = 1'b0;
        @(negedge wr_clk);
        checks++;
        if (s_ready !== 1'b1 || fifo_wr_en !== 1'b1) begin
            errors++; $display("FAIL full_resume: got ready=%b wr_en=%b, expected 1/1", s_ready, fifo_wr_en);
        end
`ifdef FIFO_PKT_WR_STATS_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++; $display("FAIL stall_cnt_payload: got %0d, expected 3", stall_cnt);
        end
`endif
        @(posedge wr_clk); #1;
        s_valid = 1'b0; s_last = 1'b0; fifo_full = 1'b1;
        repeat (2) begin
            @(negedge wr_clk);
            checks++;
            if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
                errors++; $display("FAIL full_trl_hold: got busy=%b wr_en=%b, expected 1/0", busy, fifo_wr_en);
            end
            @(posedge wr_clk); #1;
        end
        fifo_full = 1'b0;
        wait_idle();
`ifdef FIFO_PKT_WR_STATS_EN
        checks++;
        if (stall_cnt !== 16'd5 || pkt_cnt !== 16'd1) begin
            errors++; $display("FAIL stats_after_full: got stall=%0d pkt=%0d, expected 5/1", stall_cnt, pkt_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        sb.push_back({4'hA, exp_seq}); sb.push_back(8'h71);
        s_valid = 1'b1; s_data = 8'h71; s_last = 1'b0;
        @(posedge wr_clk); #1;
        @(posedge wr_clk); #1;
        s_data = 8'h72; rst = 1'b1;
        repeat (2) begin
            @(negedge wr_clk);
            checks++;
            if (fifo_wr_en !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_reset: got wr_en=%b ready=%b busy=%b, expected 0/0/0", fifo_wr_en, s_ready, busy);
            end
            @(posedge wr_clk); #1;
        end
        s_valid = 1'b0; rst = 1'b0; exp_seq = 4'd0;
        @(posedge wr_clk); #1;
        send_pkt(1, 8'h81, 1'b0);
        wait_idle();
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) send_pkt(1, 8'(i + 16), (i < 16));
        wait_idle();
`ifdef FIFO_PKT_WR_STATS_EN
        checks++;
        if (pkt_cnt !== 16'd17) begin
            errors++; $display("FAIL pkt_cnt_wrap: got %0d, expected 17", pkt_cnt);
        end
`endif
    endtask

    task automatic test_saturation();
        send_pkt(300, 8'h00, 1'b0);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; fifo_full = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_single();
        test_full_stall();
        test_mid_reset();
        test_seq_wrap();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d words left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
